ysyx_22050078_lsu: RTL and testbench

Load/store unit sitting directly downstream of the execute stage. It takes the 64-bit execute result as the effective address, or as a pass-through value for non-memory instructions, plus rs2 store data and a memory opcode. It performs one access at a time on a request/grant/response data bus. It returns the write-back value, with loads byte-extracted and sign/zero-extended, to the write-back stage through a valid/ready handshake.

---
 rtl/ysyx_22050078_lsu_pkg.sv | 62 ++++++
 rtl/ysyx_22050078_lsu_ext.sv | 31 +++
 rtl/ysyx_22050078_lsu.sv | 164 ++++++++++++++++
 tb/tb_ysyx_22050078_lsu.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050078_lsu_pkg.sv
// rtl/ysyx_22050078_lsu_pkg.sv - LSU opcodes, FSM states, size masks and decode helpers
package ysyx_22050078_lsu_pkg;

    localparam int CPU_WIDTH     = 64;
    localparam int LSU_OPT_WIDTH = 4;

    // Memory opcode carried alongside the execute result; codes 12..15 act as NONE
    typedef enum logic [LSU_OPT_WIDTH-1:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LD   = 4'd4,
        LSU_LBU  = 4'd5,
        LSU_LHU  = 4'd6,
        LSU_LWU  = 4'd7,
        LSU_SB   = 4'd8,
        LSU_SH   = 4'd9,
        LSU_SW   = 4'd10,
        LSU_SD   = 4'd11
    } lsu_opt_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Byte-enable pattern of each access size before lane shifting
    localparam logic [7:0] SIZE_MASK_B = 8'h01;
    localparam logic [7:0] SIZE_MASK_H = 8'h03;
    localparam logic [7:0] SIZE_MASK_W = 8'h0F;
    localparam logic [7:0] SIZE_MASK_D = 8'hFF;

    function automatic logic opt_is_load(input logic [LSU_OPT_WIDTH-1:0] opt);
        return (opt >= LSU_LB) && (opt <= LSU_LWU);
    endfunction

    function automatic logic opt_is_store(input logic [LSU_OPT_WIDTH-1:0] opt);
        return (opt >= LSU_SB) && (opt <= LSU_SD);
    endfunction

    function automatic logic [7:0] opt_size_mask(input logic [LSU_OPT_WIDTH-1:0] opt);
        logic [7:0] mask;
        case (opt)
            LSU_LB, LSU_LBU, LSU_SB: mask = SIZE_MASK_B;
            LSU_LH, LSU_LHU, LSU_SH: mask = SIZE_MASK_H;
            LSU_LW, LSU_LWU, LSU_SW: mask = SIZE_MASK_W;
            LSU_LD, LSU_SD:          mask = SIZE_MASK_D;
            default:                 mask = 8'h00;
        endcase
        return mask;
    endfunction

    // Address bits that must be zero for a natural-aligned access:
    // B -> 000, H -> 001, W -> 011, D -> 111 (picked straight out of the size mask)
    function automatic logic [2:0] align_lsb(input logic [7:0] size_mask);
        return {size_mask[7], size_mask[3], size_mask[1]};
    endfunction

endpackage

// File: rtl/ysyx_22050078_lsu_ext.sv
// rtl/ysyx_22050078_lsu_ext.sv - combinational load byte-extract and sign/zero-extend
module ysyx_22050078_lsu_ext
    import ysyx_22050078_lsu_pkg::*;
(
    input  logic [CPU_WIDTH-1:0]     i_rdata,
    input  logic [2:0]               i_off,
    input  logic [LSU_OPT_WIDTH-1:0] i_opt,
    output logic [CPU_WIDTH-1:0]     o_value
);

    logic [CPU_WIDTH-1:0] w_shifted;

    // Bring the addressed byte lane down to bit 0
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    // Truncate to the access size, then extend according to the opcode
    always_comb begin
        o_value = '0;
        case (i_opt)
            LSU_LB:  o_value = {{56{w_shifted[7]}},  w_shifted[7:0]};
            LSU_LH:  o_value = {{48{w_shifted[15]}}, w_shifted[15:0]};
            LSU_LW:  o_value = {{32{w_shifted[31]}}, w_shifted[31:0]};
            LSU_LD:  o_value = w_shifted;
            LSU_LBU: o_value = {56'd0, w_shifted[7:0]};
            LSU_LHU: o_value = {48'd0, w_shifted[15:0]};
            LSU_LWU: o_value = {32'd0, w_shifted[31:0]};
            default: o_value = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_22050078_lsu.sv
// rtl/ysyx_22050078_lsu.sv - load/store unit top; optional LSU_MISALIGN_CHECK_EN traps unaligned accesses
module ysyx_22050078_lsu
    import ysyx_22050078_lsu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [CPU_WIDTH-1:0]     i_exu_res,
    input  logic [CPU_WIDTH-1:0]     i_rs2_data,
    input  logic [LSU_OPT_WIDTH-1:0] i_lsu_opt,
    output logic                     o_valid,
    input  logic                     i_wb_ready,
    output logic [CPU_WIDTH-1:0]     o_lsu_res,
    output logic                     o_misalign,
    output logic                     o_mem_req,
    output logic                     o_mem_we,
    output logic [CPU_WIDTH-1:0]     o_mem_addr,
    output logic [CPU_WIDTH-1:0]     o_mem_wdata,
    output logic [7:0]               o_mem_wmask,
    input  logic                     i_mem_gnt,
    input  logic                     i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0]     i_mem_rdata
);

    lsu_state_e                 r_state;
    logic [LSU_OPT_WIDTH-1:0]   r_opt;
    logic [2:0]                 r_off;
    logic                       r_ready;
    logic                       r_valid;
    logic [CPU_WIDTH-1:0]       r_lsu_res;
    logic                       r_mem_req;
    logic                       r_mem_we;
    logic [CPU_WIDTH-1:0]       r_mem_addr;
    logic [CPU_WIDTH-1:0]       r_mem_wdata;
    logic [7:0]                 r_mem_wmask;

    logic                       w_is_load;
    logic                       w_is_store;
    logic                       w_is_mem;
    logic [7:0]                 w_size_mask;
    logic [2:0]                 w_align_lsb;
    logic [2:0]                 w_off;
    logic [CPU_WIDTH-1:0]       w_load_val;

    assign w_is_load   = opt_is_load(i_lsu_opt);
    assign w_is_store  = opt_is_store(i_lsu_opt);
    assign w_is_mem    = w_is_load | w_is_store;
    assign w_size_mask = opt_size_mask(i_lsu_opt);
    assign w_align_lsb = align_lsb(w_size_mask);
    // Sub-size address bits are dropped, so an unchecked unaligned access
    // becomes the naturally aligned access containing it
    assign w_off       = i_exu_res[2:0] & ~w_align_lsb;

`ifdef LSU_MISALIGN_CHECK_EN
    logic r_misalign;
    logic w_misaligned;

    assign w_misaligned = |(i_exu_res[2:0] & w_align_lsb);
    assign o_misalign   = r_misalign;
`else
    assign o_misalign   = 1'b0;
`endif

    ysyx_22050078_lsu_ext u_ext (
        .i_rdata (i_mem_rdata),
        .i_off   (r_off),
        .i_opt   (r_opt),
        .o_value (w_load_val)
    );

    // Request/response sequencer; every output is a register driven from here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_opt       <= LSU_NONE;
            r_off       <= 3'd0;
            r_ready     <= 1'b1;
            r_valid     <= 1'b0;
            r_lsu_res   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wmask <= 8'h00;
`ifdef LSU_MISALIGN_CHECK_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_valid) begin
                        r_ready <= 1'b0;
                        r_opt   <= i_lsu_opt;
                        r_off   <= w_off;
                        if (!w_is_mem) begin
                            r_lsu_res <= i_exu_res;
                            r_valid   <= 1'b1;
                            r_state   <= ST_RESP;
`ifdef LSU_MISALIGN_CHECK_EN
                        end else if (w_misaligned) begin
                            r_lsu_res  <= '0;
                            r_misalign <= 1'b1;
                            r_valid    <= 1'b1;
                            r_state    <= ST_RESP;
`endif
                        end else begin
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= w_is_store;
                            r_mem_addr  <= {i_exu_res[CPU_WIDTH-1:3], 3'b000};
                            r_mem_wdata <= i_rs2_data << {w_off, 3'b000};
                            r_mem_wmask <= w_size_mask << w_off;
                            r_state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_lsu_res <= '0;
                            r_valid   <= 1'b1;
                            r_state   <= ST_RESP;
                        end else if (i_mem_rvalid) begin
                            r_lsu_res <= w_load_val;
                            r_valid   <= 1'b1;
                            r_state   <= ST_RESP;
                        end else begin
                            r_state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (i_mem_rvalid) begin
                        r_lsu_res <= w_load_val;
                        r_valid   <= 1'b1;
                        r_state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_wb_ready) begin
                        r_valid   <= 1'b0;
                        r_ready   <= 1'b1;
`ifdef LSU_MISALIGN_CHECK_EN
                        r_misalign <= 1'b0;
`endif
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_valid     = r_valid;
    assign o_lsu_res   = r_lsu_res;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_wmask = r_mem_wmask;

endmodule

// File: tb/tb_ysyx_22050078_lsu.sv
// tb/tb_ysyx_22050078_lsu.sv - scoreboard bench for the load/store unit
`timescale 1ns/1ps
module tb_ysyx_22050078_lsu;
    import ysyx_22050078_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_exu_res;
    logic [63:0] i_rs2_data;
    logic [3:0]  i_lsu_opt;
    logic        o_valid;
    logic        i_wb_ready;
    logic [63:0] o_lsu_res;
    logic        o_misalign;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [63:0] o_mem_addr;
    logic [63:0] o_mem_wdata;
    logic [7:0]  o_mem_wmask;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [63:0] i_mem_rdata;

    ysyx_22050078_lsu dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_exu_res(i_exu_res), .i_rs2_data(i_rs2_data), .i_lsu_opt(i_lsu_opt),
        .o_valid(o_valid), .i_wb_ready(i_wb_ready), .o_lsu_res(o_lsu_res),
        .o_misalign(o_misalign), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask),
        .i_mem_gnt(i_mem_gnt), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] rdata;
    } bus_t;

    typedef struct packed {
        logic [63:0] res;
        logic        mis;
    } resp_t;

    bus_t  exp_bus_q[$];
    resp_t exp_resp_q[$];

    int tests = 0;
    int fails = 0;
    int force_gnt_delay = -1;
    int force_same = -1;
    bit hold_rvalid = 0;
    bit wb_hold = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: byte-level view of the access rules, independent of the RTL structure
    function automatic void ref_model(input logic [3:0] opt, input logic [63:0] a,
                                      input logic [63:0] rs2, input logic [63:0] rdata,
                                      output bit is_mem, output bus_t b, output resp_t r);
        int size;
        bit ld, st, sgn;
        logic [63:0] ea;
        int off;
        logic [63:0] v;
        size = 0; ld = 0; st = 0; sgn = 0;
        b = '0;
        r = '0;
        case (opt)
            LSU_LB:  begin size = 1; ld = 1; sgn = 1; end
            LSU_LH:  begin size = 2; ld = 1; sgn = 1; end
            LSU_LW:  begin size = 4; ld = 1; sgn = 1; end
            LSU_LD:  begin size = 8; ld = 1; end
            LSU_LBU: begin size = 1; ld = 1; end
            LSU_LHU: begin size = 2; ld = 1; end
            LSU_LWU: begin size = 4; ld = 1; end
            LSU_SB:  begin size = 1; st = 1; end
            LSU_SH:  begin size = 2; st = 1; end
            LSU_SW:  begin size = 4; st = 1; end
            LSU_SD:  begin size = 8; st = 1; end
            default: ;
        endcase
        is_mem = ld || st;
        if (!is_mem) begin
            r.res = a;
            return;
        end
`ifdef LSU_MISALIGN_CHECK_EN
        if ((a % 64'(size)) != 0) begin
            is_mem = 0;
            r.mis = 1'b1;
            r.res = '0;
            return;
        end
`endif
        ea = a - (a % 64'(size));
        off = int'(ea % 64'd8);
        b.we = st;
        b.addr = ea - 64'(off);
        b.rdata = rdata;
        b.wmask = 8'((((1 << size) - 1) << off) & 255);
        b.wdata = rs2 << (8 * off);
        if (ld) begin
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
            if (sgn && v[8*size-1])
                for (int i = size; i < 8; i++) v[8*i +: 8] = 8'hFF;
            r.res = v;
        end
    endfunction

    task automatic issue(input logic [3:0] opt, input logic [63:0] a, input logic [63:0] rs2,
                         input logic [63:0] rdata, input bit use_const, input logic [63:0] const_res);
        bus_t b;
        resp_t r;
        bit m;
        int n;
        ref_model(opt, a, rs2, rdata, m, b, r);
        if (use_const) r.res = const_res;
        n = 0;
        @(negedge clk);
        while (!o_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!o_ready) begin
            chk("accept_timeout", {63'd0, o_ready}, 64'd1);
            return;
        end
        if (m) exp_bus_q.push_back(b);
        exp_resp_q.push_back(r);
        i_valid = 1'b1;
        i_lsu_opt = opt;
        i_exu_res = a;
        i_rs2_data = rs2;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_lsu_opt = 4'($urandom);
        i_exu_res = {$urandom, $urandom};
        i_rs2_data = {$urandom, $urandom};
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_ready"}, {63'd0, o_ready}, 64'd1);
        chk({nm, "_valid"}, {63'd0, o_valid}, 64'd0);
        chk({nm, "_req"}, {63'd0, o_mem_req}, 64'd0);
        chk({nm, "_we"}, {63'd0, o_mem_we}, 64'd0);
        chk({nm, "_mis"}, {63'd0, o_misalign}, 64'd0);
        chk({nm, "_res"}, o_lsu_res, 64'd0);
        chk({nm, "_addr"}, o_mem_addr, 64'd0);
        chk({nm, "_wdata"}, o_mem_wdata, 64'd0);
        chk({nm, "_wmask"}, {56'd0, o_mem_wmask}, 64'd0);
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_resp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 64'(exp_resp_q.size()), 64'd0);
    endtask

    // Write-back stage: random backpressure, applied just after the edge
    initial begin
        i_wb_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            i_wb_ready = wb_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Memory responder: checks each request against the scoreboard and answers it
    initial begin : mem_responder
        bus_t b;
        int d, same, rd;
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata = '0;
        forever begin
            @(negedge clk);
            i_mem_gnt = 1'b0;
            i_mem_rvalid = 1'b0;
            if (rst_n && o_mem_req) begin
                if (exp_bus_q.size() == 0) begin
                    chk("unexpected_req", {63'd0, o_mem_req}, 64'd0);
                    i_mem_gnt = 1'b1;
                    @(negedge clk);
                    i_mem_gnt = 1'b0;
                end else begin
                    b = exp_bus_q.pop_front();
                    chk("bus_we", {63'd0, o_mem_we}, {63'd0, b.we});
                    chk("bus_addr", o_mem_addr, b.addr);
                    chk("bus_wdata", o_mem_wdata, b.wdata);
                    chk("bus_wmask", {56'd0, o_mem_wmask}, {56'd0, b.wmask});
                    d = (force_gnt_delay >= 0) ? force_gnt_delay : int'($urandom_range(0, 3));
                    same = (force_same >= 0) ? force_same : int'($urandom_range(0, 1));
                    force_gnt_delay = -1;
                    force_same = -1;
                    for (int k = 0; k < d; k++) begin
                        @(negedge clk);
                        chk("req_held", {63'd0, o_mem_req}, 64'd1);
                        chk("addr_held", o_mem_addr, b.addr);
                        chk("wmask_held", {56'd0, o_mem_wmask}, {56'd0, b.wmask});
                    end
                    i_mem_gnt = 1'b1;
                    if (!b.we && same != 0) begin
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata = b.rdata;
                    end else begin
                        i_mem_rdata = {$urandom, $urandom};
                    end
                    @(negedge clk);
                    i_mem_gnt = 1'b0;
                    i_mem_rvalid = 1'b0;
                    i_mem_rdata = {$urandom, $urandom};
                    if (!b.we && same == 0) begin
                        rd = int'($urandom_range(0, 3));
                        while (hold_rvalid) @(negedge clk);
                        repeat (rd) @(negedge clk);
                        i_mem_rvalid = 1'b1;
                        i_mem_rdata = b.rdata;
                        @(negedge clk);
                        i_mem_rvalid = 1'b0;
                        i_mem_rdata = {$urandom, $urandom};
                    end
                end
            end else begin
                // stray strobes while no request is open must be ignored
                i_mem_gnt = ($urandom_range(0, 7) == 0);
                i_mem_rvalid = ($urandom_range(0, 7) == 0);
                i_mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Write-back monitor: compares results at each handshake and checks hold stability
    initial begin : monitor
        resp_t e;
        logic [63:0] held_res;
        bit held;
        held = 0;
        held_res = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
            end else begin
                if (held) begin
                    chk("valid_stable", {63'd0, o_valid}, 64'd1);
                    chk("res_stable", o_lsu_res, held_res);
                end
                held = 0;
                if (o_valid) begin
                    chk("ready_low_in_resp", {63'd0, o_ready}, 64'd0);
                    if (i_wb_ready) begin
                        if (exp_resp_q.size() == 0) begin
                            chk("spurious_valid", {63'd0, o_valid}, 64'd0);
                        end else begin
                            e = exp_resp_q.pop_front();
                            chk("lsu_res", o_lsu_res, e.res);
                            chk("misalign", {63'd0, o_misalign}, {63'd0, e.mis});
                        end
                    end else begin
                        held = 1;
                        held_res = o_lsu_res;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [63:0] rd;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_lsu_opt = '0;
        i_exu_res = '0;
        i_rs2_data = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_rst");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_rst");

        // NONE: result one cycle after acceptance, no bus activity
        issue(LSU_NONE, 64'h1234, {$urandom, $urandom}, 64'd0, 1, 64'h1234);
        @(negedge clk);
        chk("none_latency", {63'd0, o_valid}, 64'd1);
        chk("none_no_req", {63'd0, o_mem_req}, 64'd0);
        chk("none_ready_low", {63'd0, o_ready}, 64'd0);
        drain("none_drain");

        // SB with grant delayed three cycles
        force_gnt_delay = 3;
        issue(LSU_SB, 64'h8000_0003, 64'hAB, 64'd0, 1, 64'd0);
        @(negedge clk);
        chk("sb_addr", o_mem_addr, 64'h8000_0000);
        chk("sb_wmask", {56'd0, o_mem_wmask}, 64'h08);
        chk("sb_wdata", o_mem_wdata, 64'h0000_0000_AB00_0000);
        chk("sb_we", {63'd0, o_mem_we}, 64'd1);
        drain("sb_drain");

        issue(LSU_LB, 64'h8000_0005, {$urandom, $urandom}, 64'h0000_8000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FF80);
        issue(LSU_LBU, 64'h8000_0005, {$urandom, $urandom}, 64'h0000_8000_0000_0000, 1, 64'h80);
        drain("lb_drain");

        // LW with grant and data together; write-back stalls two cycles
        wb_hold = 1;
        force_gnt_delay = 0;
        force_same = 1;
        issue(LSU_LW, 64'h8000_0004, {$urandom, $urandom}, 64'h8765_4321_DEAD_BEEF, 1, 64'hFFFF_FFFF_8765_4321);
        @(negedge clk);
        chk("lw_req", {63'd0, o_mem_req}, 64'd1);
        @(negedge clk);
        chk("lw_min_latency", {63'd0, o_valid}, 64'd1);
        chk("lw_res", o_lsu_res, 64'hFFFF_FFFF_8765_4321);
        repeat (2) @(negedge clk);
        wb_hold = 0;
        drain("lw_drain");

        rd = {$urandom, $urandom};
`ifdef LSU_MISALIGN_CHECK_EN
        issue(LSU_LD, 64'h8000_0002, {$urandom, $urandom}, rd, 1, 64'd0);
        @(negedge clk);
        chk("ld_mis_no_req", {63'd0, o_mem_req}, 64'd0);
        chk("ld_mis_flag", {63'd0, o_misalign}, 64'd1);
`else
        issue(LSU_LD, 64'h8000_0002, {$urandom, $urandom}, rd, 1, rd);
        @(negedge clk);
        chk("ld_aligned_addr", o_mem_addr, 64'h8000_0000);
`endif
        drain("ld_drain");

        for (int i = 0; i < 250; i++) begin
            issue(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 0, 64'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("rand_drain");

        // Reset while waiting for load data; the late response must be ignored
        hold_rvalid = 1;
        force_gnt_delay = 0;
        force_same = 0;
        issue(LSU_LD, 64'h8000_0010, {$urandom, $urandom}, {$urandom, $urandom}, 0, 64'd0);
        repeat (3) @(negedge clk);
        chk("wait_busy", {63'd0, o_ready}, 64'd0);
        chk("wait_no_valid", {63'd0, o_valid}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", {63'd0, o_ready}, 64'd1);
        chk("async_rst_req", {63'd0, o_mem_req}, 64'd0);
        exp_resp_q.delete();
        exp_bus_q.delete();
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_rst");
        rst_n = 1'b1;
        hold_rvalid = 0;
        repeat (8) begin
            @(negedge clk);
            chk("late_rsp_no_valid", {63'd0, o_valid}, 64'd0);
            chk("late_rsp_ready", {63'd0, o_ready}, 64'd1);
        end
        check_reset_outputs("after_late");

        for (int i = 0; i < 40; i++) begin
            issue(4'($urandom_range(0, 11)), {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, 0, 64'd0);
        end
        drain("final_drain");
        repeat (3) @(negedge clk);
        chk("bus_q_empty", 64'(exp_bus_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
